piso_serial_tx: RTL and testbench



---
 rtl/piso_pkg.sv | 8 +
 rtl/piso_bit_counter.sv | 35 +++
 rtl/piso_serial_tx.sv | 127 ++++++++++++
 tb/tb_piso_serial_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_serial_tx slice.
package piso_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; holds at zero.
module piso_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless frames.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serial_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned SH_W  = FRAME_LEN - 1;
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  piso_state_t     state_q, state_d;
  logic [SH_W-1:0] shreg_q, shreg_d;
  logic            data_out_q, data_out_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_start_q, frame_start_d;

  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 handshake;
  logic [WIDTH-1:0]     data_ord;
  logic [FRAME_LEN-1:0] frame_vec;

  piso_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(LAST_IDX),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero);
  assign handshake  = load_valid && load_ready;

  // Whole frame is laid out so its first bit is at the top; every bit order
  // (and the parity tail) then becomes a uniform left shift.
  always_comb begin
    data_ord = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      data_ord[i] = MSB_FIRST ? load_data[i] : load_data[WIDTH-1-i];
    end
`ifdef PISO_PARITY_EN
    frame_vec = {data_ord, ^load_data};
`else
    frame_vec = data_ord;
`endif
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    data_out_d    = data_out_q;
    out_valid_d   = out_valid_q;
    frame_start_d = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    if (handshake) begin
      state_d       = SHIFT;
      shreg_d       = frame_vec[SH_W-1:0];
      data_out_d    = frame_vec[FRAME_LEN-1];
      out_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      cnt_load      = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_zero) begin
            state_d     = IDLE;
            data_out_d  = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            data_out_d = shreg_q[SH_W-1];
            shreg_d    = shreg_q << 1;
            cnt_dec    = 1'b1;
          end
        end
        default: begin
          data_out_d  = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      data_out_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      data_out_q    <= data_out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = out_valid_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: MSB-first and LSB-first instances share stimulus.
module tb_piso_serial_tx;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;

  logic rdy_m, dout_m, ov_m, fs_m, busy_m;
  logic rdy_l, dout_l, ov_l, fs_l, busy_l;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Each entry is {expected data bit, expected frame_start}.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [1:0] e_m, e_l;
  logic       exp_v_m, exp_v_l;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_m), .data_out(dout_m), .out_valid(ov_m),
    .frame_start(fs_m), .busy(busy_m)
  );

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy_l), .data_out(dout_l), .out_valid(ov_l),
    .frame_start(fs_l), .busy(busy_l)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived bit orders: MSB-first sends w[7]..w[0], LSB-first w[0]..w[7].
  function automatic void push_frame(input logic [W-1:0] w);
    for (int i = 0; i < int'(W); i++) begin
      q_m.push_back({w[W-1-i], (i == 0)});
      q_l.push_back({w[i], (i == 0)});
    end
`ifdef PISO_PARITY_EN
    q_m.push_back({^w, 1'b0});
    q_l.push_back({^w, 1'b0});
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      exp_v_m = (q_m.size() != 0);
      check("m_busy", busy_m, exp_v_m);
      if (exp_v_m) begin
        e_m = q_m.pop_front();
        check("m_out_valid", ov_m, 1);
        check("m_data_out", dout_m, e_m[1]);
        check("m_frame_start", fs_m, e_m[0]);
      end else begin
        check("m_idle_valid", ov_m, 0);
        check("m_idle_data", dout_m, 0);
        check("m_idle_fstart", fs_m, 0);
      end
      exp_v_l = (q_l.size() != 0);
      check("l_busy", busy_l, exp_v_l);
      if (exp_v_l) begin
        e_l = q_l.pop_front();
        check("l_out_valid", ov_l, 1);
        check("l_data_out", dout_l, e_l[1]);
        check("l_frame_start", fs_l, e_l[0]);
      end else begin
        check("l_idle_valid", ov_l, 0);
        check("l_idle_data", dout_l, 0);
        check("l_idle_fstart", fs_l, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge showing the frame's first bit.
  task automatic send(input logic [W-1:0] w, output int unsigned waited);
    load_data  = w;
    load_valid = 1'b1;
    waited     = 0;
    while (!rdy_m && waited < 4 * FL) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy_m) begin
      miscompares++;
      $display("FAIL handshake_timeout: load_ready stayed %0b for word %0h", rdy_m, w);
      load_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_frame(w);
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = W'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < int'(4 * FL) && q_m.size() != 0; i++) @(negedge clk);
    if (q_m.size() != 0 || q_l.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d/%0d bits still pending", q_m.size(), q_l.size());
      q_m.delete();
      q_l.delete();
    end
    @(negedge clk);
  endtask

  int unsigned waited;

  initial begin
    #12;
    check("rst_data_out", dout_m, 0);
    check("rst_out_valid", ov_m, 0);
    check("rst_frame_start", fs_m, 0);
    check("rst_busy", busy_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", rdy_m, 1);
    @(negedge clk);

    // Basic frame; load_ready only on the last-bit cycle and the idle cycle after.
    send(8'hB4, waited);
    for (int unsigned c = 1; c <= FL + 1; c++) begin
      check($sformatf("ready_cycle%0d", c), rdy_m, (c >= FL) ? 1 : 0);
      check($sformatf("ready_l_cycle%0d", c), rdy_l, (c >= FL) ? 1 : 0);
      if (c < FL + 1) @(negedge clk);
    end
    drain();

    // Back-to-back: second word handshakes on the last-bit cycle, no gap.
    send(8'hFF, waited);
    send(8'h00, waited);
    check("b2b_wait", waited, FL - 1);
    drain();

    // Backpressure: 0x5A offered during bit 3 waits for the last-bit cycle.
    send(8'hB4, waited);
    @(negedge clk);
    @(negedge clk);
    load_data  = 8'h5A;
    load_valid = 1'b1;
    #1 check("bp_ready_low", rdy_m, 0);
    send(8'h5A, waited);
    check("bp_wait", waited, FL - 3);
    drain();

    // Asynchronous reset mid-frame, then a fresh frame.
    send(8'hB4, waited);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data_out", dout_m, 0);
    check("midrst_out_valid", ov_m, 0);
    check("midrst_frame_start", fs_m, 0);
    check("midrst_busy", busy_m, 0);
    check("midrst_l_out_valid", ov_l, 0);
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready", rdy_m, 1);
    @(negedge clk);
    send(8'hC3, waited);
    drain();

    // Odd-weight word: parity bit 1 when parity is built in.
    send(8'hB5, waited);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
